// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Frame: length byte, 4*N big-endian data bytes, mod-256 checksum byte.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W    = 6;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream, first byte most significant, into 32-bit words.
// Emits a one-cycle registered word_valid with the completed word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic [BCNT_W-1:0] o_bcnt,
  output logic [31:0]       o_word,
  output logic              o_word_valid
);

  localparam int SH_W = 8 * (BYTES_PER_WORD - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);

  logic [SH_W-1:0]   r_sh;
  logic [BCNT_W-1:0] r_bcnt;
  logic [31:0]       r_word;
  logic              r_word_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh         <= '0;
      r_bcnt       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clr) begin
      r_sh         <= '0;
      r_bcnt       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_bcnt <= r_bcnt + 1'b1;
        if (r_bcnt == BCNT_LAST) begin
          r_word       <= {r_sh, i_byte};
          r_word_valid <= 1'b1;
        end else begin
          r_sh <= {r_sh[SH_W-9:0], i_byte};
        end
      end
    end
  end

  assign o_bcnt       = r_bcnt;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_loader.sv
// Framed serial loader for the writable instruction RAM.
// Holds the core in reset until a frame passes its checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WORDS = 1 << ADDR_W;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_wa;
  logic [7:0]        r_sum;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic              w_xfer;
  logic              w_pk_in;
  logic              w_pk_clr;
  logic              w_word_end;
  logic [BCNT_W-1:0] w_bcnt;
  logic [ADDR_W-1:0] w_last;

  assign byte_ready = (r_state == ST_LEN) ||
                      (r_state == ST_DATA) ||
                      (r_state == ST_CSUM);
  assign w_xfer     = byte_valid && byte_ready;
  assign w_pk_in    = w_xfer && (r_state == ST_DATA);
  assign w_pk_clr   = start && !byte_ready;
  assign w_word_end = w_pk_in && (w_bcnt == BCNT_LAST);

  // Length 0 and anything above the RAM size both mean a full image.
  always_comb begin
    w_last = ADDR_W'(WORDS - 1);
    if (byte_data != 8'd0 && int'(byte_data) <= WORDS)
      w_last = ADDR_W'(byte_data - 8'd1);
  end

  imem_loader_byte_packer u_byte_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_pk_clr),
    .i_valid      (w_pk_in),
    .i_byte       (byte_data),
    .o_bcnt       (w_bcnt),
    .o_word       (wd),
    .o_word_valid (we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= '0;
      r_wcnt      <= '0;
      r_wa        <= '0;
      r_sum       <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state     <= ST_LEN;
            r_wcnt      <= '0;
            r_sum       <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
          end
        end
        ST_LEN: begin
          if (w_xfer) begin
            r_last  <= w_last;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_pk_in)
            r_sum <= r_sum + byte_data;
          if (w_word_end) begin
            r_wa   <= r_wcnt;
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == r_last)
              r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_busy <= 1'b0;
            if (byte_data == r_sum) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wa        = r_wa;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule
